// File: rtl/carfield_reg_mailbox.sv
// Register-bus mailbox: TX/RX word FIFOs exposed as registers and as valid/ready streams.
// Optional interrupt registers are built when CARFIELD_MAILBOX_IRQ_EN is defined.
module carfield_reg_mailbox #(
  parameter int unsigned Depth       = 4,
  parameter int unsigned OffsetWidth = 12
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [47:0] reg_addr_i,
  input  logic        reg_write_i,
  input  logic [31:0] reg_wdata_i,
  input  logic [3:0]  reg_wstrb_i,
  input  logic        reg_valid_i,
  output logic [31:0] reg_rdata_o,
  output logic        reg_error_o,
  output logic        reg_ready_o,
  output logic [31:0] tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [31:0] rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        irq_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  localparam logic [OffsetWidth-1:0] OffTxData  = OffsetWidth'('h00);
  localparam logic [OffsetWidth-1:0] OffRxData  = OffsetWidth'('h04);
  localparam logic [OffsetWidth-1:0] OffStatus  = OffsetWidth'('h08);
  localparam logic [OffsetWidth-1:0] OffCtrl    = OffsetWidth'('h0C);
`ifdef CARFIELD_MAILBOX_IRQ_EN
  localparam logic [OffsetWidth-1:0] OffIrqEn   = OffsetWidth'('h10);
  localparam logic [OffsetWidth-1:0] OffIrqPend = OffsetWidth'('h14);
`endif

  typedef enum logic {IDLE, RESP} state_t;

  state_t state_q, state_d;

  logic [31:0]     tx_mem [Depth];
  logic [PtrW-1:0] tx_wptr, tx_rptr;
  logic [CntW-1:0] tx_count;
  logic [31:0]     rx_mem [Depth];
  logic [PtrW-1:0] rx_wptr, rx_rptr;
  logic [CntW-1:0] rx_count;

  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;
  logic        tx_push, tx_pop, tx_flush, rx_push, rx_pop, rx_flush;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        accept;
  logic [OffsetWidth-1:0] offset;
  logic [31:0] status;
  logic        unused_addr;

`ifdef CARFIELD_MAILBOX_IRQ_EN
  logic [1:0] irq_en_q;
  logic [1:0] irq_pend;
  logic       irq_en_we;
  logic       irq_q;
`endif

  assign offset      = reg_addr_i[OffsetWidth-1:0];
  assign unused_addr = ^reg_addr_i[47:OffsetWidth];
  assign accept      = (state_q == IDLE) && reg_valid_i;

  assign tx_full  = (tx_count == CntW'(Depth));
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == CntW'(Depth));
  assign rx_empty = (rx_count == '0);

  assign tx_valid_o  = !tx_empty;
  assign tx_data_o   = tx_mem[tx_rptr];
  assign tx_pop      = tx_valid_o && tx_ready_i;
  assign rx_ready_o  = !rx_full && !rst_i;
  assign rx_push     = rx_valid_i && rx_ready_o;
  assign reg_ready_o = (state_q == RESP);
  assign reg_rdata_o = rdata_q;
  assign reg_error_o = error_q;

  assign status = {8'h00, 8'(rx_count), 8'(tx_count), 4'h0,
                   rx_empty, rx_full, tx_empty, tx_full};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rdata_q <= rdata_d;
        error_q <= error_d;
      end
    end
  end

  // Decode and side-effect strobes; full/empty here are start-of-cycle occupancy.
  always_comb begin
    state_d  = state_q;
    rdata_d  = '0;
    error_d  = 1'b0;
    tx_push  = 1'b0;
    rx_pop   = 1'b0;
    tx_flush = 1'b0;
    rx_flush = 1'b0;
`ifdef CARFIELD_MAILBOX_IRQ_EN
    irq_en_we = 1'b0;
`endif
    case (state_q)
      IDLE: if (reg_valid_i) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      case (offset)
        OffTxData: begin
          if (!reg_write_i || tx_full || reg_wstrb_i != 4'hF) error_d = 1'b1;
          else tx_push = 1'b1;
        end
        OffRxData: begin
          if (reg_write_i || rx_empty) error_d = 1'b1;
          else begin
            rx_pop  = 1'b1;
            rdata_d = rx_mem[rx_rptr];
          end
        end
        OffStatus: if (!reg_write_i) rdata_d = status;
        OffCtrl: begin
          if (reg_write_i) begin
            tx_flush = reg_wdata_i[0];
            rx_flush = reg_wdata_i[1];
          end
        end
`ifdef CARFIELD_MAILBOX_IRQ_EN
        OffIrqEn: begin
          if (reg_write_i) irq_en_we = reg_wstrb_i[0];
          else rdata_d = {30'h0, irq_en_q};
        end
        OffIrqPend: if (!reg_write_i) rdata_d = {30'h0, irq_pend};
`endif
        default: error_d = 1'b1;
      endcase
    end
  end

  // Flush wins over a concurrent push; a concurrent stream pop still left the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) tx_mem[i] <= '0;
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_mem[tx_wptr] <= reg_wdata_i;
      if (tx_flush) begin
        tx_wptr  <= '0;
        tx_rptr  <= '0;
        tx_count <= '0;
      end else begin
        if (tx_push) tx_wptr <= tx_wptr + PtrW'(1);
        if (tx_pop)  tx_rptr <= tx_rptr + PtrW'(1);
        if (tx_push && !tx_pop)      tx_count <= tx_count + CntW'(1);
        else if (!tx_push && tx_pop) tx_count <= tx_count - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) rx_mem[i] <= '0;
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_mem[rx_wptr] <= rx_data_i;
      if (rx_flush) begin
        rx_wptr  <= '0;
        rx_rptr  <= '0;
        rx_count <= '0;
      end else begin
        if (rx_push) rx_wptr <= rx_wptr + PtrW'(1);
        if (rx_pop)  rx_rptr <= rx_rptr + PtrW'(1);
        if (rx_push && !rx_pop)      rx_count <= rx_count + CntW'(1);
        else if (!rx_push && rx_pop) rx_count <= rx_count - CntW'(1);
      end
    end
  end

`ifdef CARFIELD_MAILBOX_IRQ_EN
  assign irq_pend = {tx_empty, !rx_empty};
  assign irq_o    = irq_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (irq_en_we) irq_en_q <= reg_wdata_i[1:0];
      irq_q <= |(irq_en_q & irq_pend);
    end
  end
`else
  assign irq_o = 1'b0;
`endif

endmodule
